// File: rtl/xbar_sched.sv
// rtl/xbar_sched.sv - entry allocation, oldest-first selection and per-bank round-robin for the crossbar buffer
// Ports: clk/rst; per channel c: u_channel_c_req_valid/bank_id in, u_channel_c_req_ready/ch_c_w_ptr out;
//        per bank k: d_bank_k_valid/bank_k_ch_1hot_id out, d_bank_k_ready in;
//        ch_c_bank_k_r_entry_1hot_id out (oldest channel c entry waiting for bank k).
module xbar_sched #(
    parameter int NumCh    = 3,
    parameter int NumBank  = 4,
    parameter int NumEntry = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u_channel_0_req_valid,
    input  logic [1:0] u_channel_0_bank_id,
    output logic       u_channel_0_req_ready,
    output logic [2:0] ch_0_w_ptr,
    input  logic       u_channel_1_req_valid,
    input  logic [1:0] u_channel_1_bank_id,
    output logic       u_channel_1_req_ready,
    output logic [2:0] ch_1_w_ptr,
    input  logic       u_channel_2_req_valid,
    input  logic [1:0] u_channel_2_bank_id,
    output logic       u_channel_2_req_ready,
    output logic [2:0] ch_2_w_ptr,
    output logic       d_bank_0_valid,
    input  logic       d_bank_0_ready,
    output logic [2:0] bank_0_ch_1hot_id,
    output logic       d_bank_1_valid,
    input  logic       d_bank_1_ready,
    output logic [2:0] bank_1_ch_1hot_id,
    output logic       d_bank_2_valid,
    input  logic       d_bank_2_ready,
    output logic [2:0] bank_2_ch_1hot_id,
    output logic       d_bank_3_valid,
    input  logic       d_bank_3_ready,
    output logic [2:0] bank_3_ch_1hot_id,
    output logic [7:0] ch_0_bank_0_r_entry_1hot_id,
    output logic [7:0] ch_0_bank_1_r_entry_1hot_id,
    output logic [7:0] ch_0_bank_2_r_entry_1hot_id,
    output logic [7:0] ch_0_bank_3_r_entry_1hot_id,
    output logic [7:0] ch_1_bank_0_r_entry_1hot_id,
    output logic [7:0] ch_1_bank_1_r_entry_1hot_id,
    output logic [7:0] ch_1_bank_2_r_entry_1hot_id,
    output logic [7:0] ch_1_bank_3_r_entry_1hot_id,
    output logic [7:0] ch_2_bank_0_r_entry_1hot_id,
    output logic [7:0] ch_2_bank_1_r_entry_1hot_id,
    output logic [7:0] ch_2_bank_2_r_entry_1hot_id,
    output logic [7:0] ch_2_bank_3_r_entry_1hot_id
);

    logic                req_valid [NumCh];
    logic [1:0]          req_bank  [NumCh];
    logic                d_ready   [NumBank];

    // age_q[c][i][j] = 1 means entry i of channel c is older than entry j
    logic [NumEntry-1:0] valid_q [NumCh],           valid_d [NumCh];
    logic [1:0]          bank_q  [NumCh][NumEntry], bank_d  [NumCh][NumEntry];
    logic [NumEntry-1:0] age_q   [NumCh][NumEntry], age_d   [NumCh][NumEntry];
    logic [1:0]          rr_q    [NumBank],         rr_d    [NumBank];
    // held_q freezes a grant that was offered but not yet accepted
    logic                held_q  [NumBank],         held_d  [NumBank];
    logic [NumCh-1:0]    hgnt_q  [NumBank],         hgnt_d  [NumBank];

    logic                ready   [NumCh];
    logic [2:0]          w_ptr   [NumCh];
    logic [NumEntry-1:0] cand    [NumCh][NumBank];
    logic [NumEntry-1:0] sel     [NumCh][NumBank];
    logic [NumCh-1:0]    arb     [NumBank];
    logic [NumCh-1:0]    gnt     [NumBank];

    assign req_valid[0] = u_channel_0_req_valid;
    assign req_valid[1] = u_channel_1_req_valid;
    assign req_valid[2] = u_channel_2_req_valid;
    assign req_bank[0]  = u_channel_0_bank_id;
    assign req_bank[1]  = u_channel_1_bank_id;
    assign req_bank[2]  = u_channel_2_bank_id;
    assign d_ready[0]   = d_bank_0_ready;
    assign d_ready[1]   = d_bank_1_ready;
    assign d_ready[2]   = d_bank_2_ready;
    assign d_ready[3]   = d_bank_3_ready;

    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            ready[c] = |(~valid_q[c]);
            w_ptr[c] = 3'd0;
            // scan downward so the lowest free index wins
            for (int e = NumEntry - 1; e >= 0; e--) begin
                if (!valid_q[c][e]) w_ptr[c] = 3'(e);
            end
            for (int k = 0; k < NumBank; k++) begin
                for (int e = 0; e < NumEntry; e++) begin
                    cand[c][k][e] = valid_q[c][e] && (bank_q[c][e] == 2'(k));
                end
                sel[c][k] = cand[c][k];
                // drop any candidate that has an older candidate for the same bank
                for (int e = 0; e < NumEntry; e++) begin
                    for (int j = 0; j < NumEntry; j++) begin
                        if (j != e && cand[c][k][j] && age_q[c][j][e]) sel[c][k][e] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NumBank; k++) begin
            arb[k] = '0;
            for (int off = 0; off < NumCh; off++) begin
                int idx;
                idx = int'(rr_q[k]) + off;
                if (idx >= NumCh) idx = idx - NumCh;
                if (arb[k] == '0 && |sel[idx][k]) arb[k][idx] = 1'b1;
            end
            gnt[k] = held_q[k] ? hgnt_q[k] : arb[k];
        end
    end

    always_comb begin
        valid_d = valid_q;
        bank_d  = bank_q;
        age_d   = age_q;
        rr_d    = rr_q;
        for (int k = 0; k < NumBank; k++) begin
            held_d[k] = (|gnt[k]) && !d_ready[k];
            hgnt_d[k] = gnt[k];
            if ((|gnt[k]) && d_ready[k]) begin
                for (int c = 0; c < NumCh; c++) begin
                    if (gnt[k][c]) begin
                        valid_d[c] = valid_d[c] & ~sel[c][k];
                        rr_d[k]    = (c == NumCh - 1) ? 2'd0 : 2'(c + 1);
                    end
                end
            end
        end
        // allocation only targets a free entry, so it never collides with a free above
        for (int c = 0; c < NumCh; c++) begin
            if (req_valid[c] && ready[c]) begin
                valid_d[c][w_ptr[c]]       = 1'b1;
                bank_d[c][w_ptr[c]]        = req_bank[c];
                age_d[c][w_ptr[c]]         = '0;
                for (int j = 0; j < NumEntry; j++) begin
                    if (3'(j) != w_ptr[c]) age_d[c][j][w_ptr[c]] = valid_q[c][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NumCh; c++) begin
                valid_q[c] <= '0;
                for (int e = 0; e < NumEntry; e++) begin
                    bank_q[c][e] <= '0;
                    age_q[c][e]  <= '0;
                end
            end
            for (int k = 0; k < NumBank; k++) begin
                rr_q[k]   <= '0;
                held_q[k] <= 1'b0;
                hgnt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            bank_q  <= bank_d;
            age_q   <= age_d;
            rr_q    <= rr_d;
            held_q  <= held_d;
            hgnt_q  <= hgnt_d;
        end
    end

    assign u_channel_0_req_ready = ready[0];
    assign u_channel_1_req_ready = ready[1];
    assign u_channel_2_req_ready = ready[2];
    assign ch_0_w_ptr = w_ptr[0];
    assign ch_1_w_ptr = w_ptr[1];
    assign ch_2_w_ptr = w_ptr[2];
    assign bank_0_ch_1hot_id = gnt[0];
    assign bank_1_ch_1hot_id = gnt[1];
    assign bank_2_ch_1hot_id = gnt[2];
    assign bank_3_ch_1hot_id = gnt[3];
    assign d_bank_0_valid = |gnt[0];
    assign d_bank_1_valid = |gnt[1];
    assign d_bank_2_valid = |gnt[2];
    assign d_bank_3_valid = |gnt[3];
    assign ch_0_bank_0_r_entry_1hot_id = sel[0][0];
    assign ch_0_bank_1_r_entry_1hot_id = sel[0][1];
    assign ch_0_bank_2_r_entry_1hot_id = sel[0][2];
    assign ch_0_bank_3_r_entry_1hot_id = sel[0][3];
    assign ch_1_bank_0_r_entry_1hot_id = sel[1][0];
    assign ch_1_bank_1_r_entry_1hot_id = sel[1][1];
    assign ch_1_bank_2_r_entry_1hot_id = sel[1][2];
    assign ch_1_bank_3_r_entry_1hot_id = sel[1][3];
    assign ch_2_bank_0_r_entry_1hot_id = sel[2][0];
    assign ch_2_bank_1_r_entry_1hot_id = sel[2][1];
    assign ch_2_bank_2_r_entry_1hot_id = sel[2][2];
    assign ch_2_bank_3_r_entry_1hot_id = sel[2][3];

endmodule

// File: tb/tb_xbar_sched.sv
// tb/tb_xbar_sched.sv - directed self-checking bench for xbar_sched
module tb_xbar_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       v     [3];
    logic [1:0] bid   [3];
    logic       rdy   [3];
    logic [2:0] wp    [3];
    logic       dv    [4];
    logic       dr    [4];
    logic [2:0] gnt   [4];
    logic [7:0] ent   [3][4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xbar_sched dut (
        .clk(clk), .rst(rst),
        .u_channel_0_req_valid(v[0]), .u_channel_0_bank_id(bid[0]),
        .u_channel_0_req_ready(rdy[0]), .ch_0_w_ptr(wp[0]),
        .u_channel_1_req_valid(v[1]), .u_channel_1_bank_id(bid[1]),
        .u_channel_1_req_ready(rdy[1]), .ch_1_w_ptr(wp[1]),
        .u_channel_2_req_valid(v[2]), .u_channel_2_bank_id(bid[2]),
        .u_channel_2_req_ready(rdy[2]), .ch_2_w_ptr(wp[2]),
        .d_bank_0_valid(dv[0]), .d_bank_0_ready(dr[0]), .bank_0_ch_1hot_id(gnt[0]),
        .d_bank_1_valid(dv[1]), .d_bank_1_ready(dr[1]), .bank_1_ch_1hot_id(gnt[1]),
        .d_bank_2_valid(dv[2]), .d_bank_2_ready(dr[2]), .bank_2_ch_1hot_id(gnt[2]),
        .d_bank_3_valid(dv[3]), .d_bank_3_ready(dr[3]), .bank_3_ch_1hot_id(gnt[3]),
        .ch_0_bank_0_r_entry_1hot_id(ent[0][0]), .ch_0_bank_1_r_entry_1hot_id(ent[0][1]),
        .ch_0_bank_2_r_entry_1hot_id(ent[0][2]), .ch_0_bank_3_r_entry_1hot_id(ent[0][3]),
        .ch_1_bank_0_r_entry_1hot_id(ent[1][0]), .ch_1_bank_1_r_entry_1hot_id(ent[1][1]),
        .ch_1_bank_2_r_entry_1hot_id(ent[1][2]), .ch_1_bank_3_r_entry_1hot_id(ent[1][3]),
        .ch_2_bank_0_r_entry_1hot_id(ent[2][0]), .ch_2_bank_1_r_entry_1hot_id(ent[2][1]),
        .ch_2_bank_2_r_entry_1hot_id(ent[2][2]), .ch_2_bank_3_r_entry_1hot_id(ent[2][3])
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        for (int c = 0; c < 3; c++) begin
            v[c]   = 1'b0;
            bid[c] = 2'd0;
        end
        for (int k = 0; k < 4; k++) dr[k] = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk_eq({tag, "_ready"}, 32'(rdy[c]), 32'd1);
            chk_eq({tag, "_wptr"}, 32'(wp[c]), 32'd0);
            for (int k = 0; k < 4; k++) chk_eq({tag, "_ent"}, 32'(ent[c][k]), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            chk_eq({tag, "_dvalid"}, 32'(dv[k]), 32'd0);
            chk_eq({tag, "_gnt"}, 32'(gnt[k]), 32'd0);
        end
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("idle");

        // channel 0: three requests to stalled bank 2
        v[0] = 1'b1; bid[0] = 2'd2;
        chk_eq("wptr_a0", 32'(wp[0]), 32'd0);
        tick();
        chk_eq("wptr_a1", 32'(wp[0]), 32'd1);
        chk_eq("vis_n1", 32'(ent[0][2]), 32'h01);
        chk_eq("dvalid2_on", 32'(dv[2]), 32'd1);
        tick();
        chk_eq("wptr_a2", 32'(wp[0]), 32'd2);
        tick();
        v[0] = 1'b0;
        chk_eq("wptr_a3", 32'(wp[0]), 32'd3);
        chk_eq("oldest_e0", 32'(ent[0][2]), 32'h01);
        chk_eq("gnt2_ch0", 32'(gnt[2]), 32'b001);
        dr[2] = 1'b1;
        tick();
        dr[2] = 1'b0;
        chk_eq("oldest_e1", 32'(ent[0][2]), 32'h02);
        chk_eq("wptr_reuse", 32'(wp[0]), 32'd0);
        chk_eq("gnt2_ch0_b", 32'(gnt[2]), 32'b001);
        // rr_2 is now 1, so channel 1 would win a fresh arbitration; stalled grant must hold
        v[1] = 1'b1; bid[1] = 2'd2;
        tick();
        v[1] = 1'b0;
        chk_eq("gnt2_hold", 32'(gnt[2]), 32'b001);
        chk_eq("hold_ent0", 32'(ent[0][2]), 32'h02);
        chk_eq("ch1_ent", 32'(ent[1][2]), 32'h01);
        dr[2] = 1'b1;
        tick();
        dr[2] = 1'b0;
        chk_eq("gnt2_rr", 32'(gnt[2]), 32'b010);
        chk_eq("oldest_e2", 32'(ent[0][2]), 32'h04);

        // channel 1 full with bank 0 requests
        do_reset();
        v[1] = 1'b1; bid[1] = 2'd0;
        for (int i = 0; i < 8; i++) begin
            chk_eq("fill_ready", 32'(rdy[1]), 32'd1);
            tick();
        end
        chk_eq("full_ready", 32'(rdy[1]), 32'd0);
        bid[1] = 2'd3;
        tick();
        tick();
        v[1] = 1'b0;
        chk_eq("full_ready2", 32'(rdy[1]), 32'd0);
        chk_eq("full_ignored", 32'(ent[1][3]), 32'h00);
        chk_eq("full_oldest", 32'(ent[1][0]), 32'h01);
        dr[0] = 1'b1;
        tick();
        dr[0] = 1'b0;
        chk_eq("unfull_ready", 32'(rdy[1]), 32'd1);
        chk_eq("unfull_wptr", 32'(wp[1]), 32'd0);
        chk_eq("unfull_oldest", 32'(ent[1][0]), 32'h02);

        // round robin over three channels on bank 3
        do_reset();
        dr[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            v[c] = 1'b1; bid[c] = 2'd3;
        end
        tick();
        for (int c = 0; c < 3; c++) v[c] = 1'b0;
        chk_eq("rr_g0", 32'(gnt[3]), 32'b001);
        tick();
        chk_eq("rr_g1", 32'(gnt[3]), 32'b010);
        tick();
        chk_eq("rr_g2", 32'(gnt[3]), 32'b100);
        tick();
        chk_eq("rr_done", 32'(dv[3]), 32'd0);
        dr[3] = 1'b0;

        // simultaneous allocate and free on channel 2
        do_reset();
        v[2] = 1'b1; bid[2] = 2'd1;
        tick();
        bid[2] = 2'd0;
        tick();
        tick();
        bid[2] = 2'd3;
        chk_eq("sim_wptr3", 32'(wp[2]), 32'd3);
        chk_eq("sim_dv1", 32'(dv[1]), 32'd1);
        dr[1] = 1'b1;
        tick();
        v[2] = 1'b0; dr[1] = 1'b0;
        chk_eq("sim_freed", 32'(ent[2][1]), 32'h00);
        chk_eq("sim_dv1_off", 32'(dv[1]), 32'd0);
        chk_eq("sim_new", 32'(ent[2][3]), 32'h08);
        chk_eq("sim_wptr0", 32'(wp[2]), 32'd0);
        chk_eq("sim_bank0", 32'(ent[2][0]), 32'h02);

        // reset mid-operation with a stalled bank and rr_2 advanced
        do_reset();
        v[0] = 1'b1; v[1] = 1'b1; bid[0] = 2'd2; bid[1] = 2'd2;
        tick();
        v[0] = 1'b0; v[1] = 1'b0;
        dr[2] = 1'b1;
        tick();
        dr[2] = 1'b0;
        chk_eq("pre_rst_gnt", 32'(gnt[2]), 32'b010);
        v[0] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v[0] = 1'b0;
        chk_idle("rst_mid");
        v[0] = 1'b1; v[1] = 1'b1;
        tick();
        v[0] = 1'b0; v[1] = 1'b0;
        chk_eq("rst_rr0", 32'(gnt[2]), 32'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_sched.md
# xbar_sched

Allocation and scheduling controller for the crossbar request buffer. For each of 3 upstream channels it tracks 8 buffer entries: which are free, which bank each occupant targets, and their age. It drives the entry write pointers, per-channel ready, per-bank channel selects and per-bank read-entry selects consumed by the crossbar buffer. It also handshakes with the 4 downstream banks and frees an entry when its bank accepts it.

## Interface
Parameters:
- NumCh, 3: channel count (fixed to 3 for this revision).
- NumBank, 4: bank count (fixed to 4).
- NumEntry, 8: entries per channel (fixed to 8; pointers are 3 bits).

Ports (c = 0..2, k = 0..3):
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- u_channel_c_req_valid  in  1  upstream request valid on channel c.
- u_channel_c_bank_id  in  2  target bank of the channel c request.
- u_channel_c_req_ready  out  1  channel c has a free entry.
- ch_c_w_ptr  out  3  entry index written on a channel c handshake.
- d_bank_k_valid  out  1  bank k has a selected request.
- d_bank_k_ready  in  1  bank k accepts the request.
- bank_k_ch_1hot_id  out  3  one-hot channel granted to bank k (0 when none).
- ch_c_bank_k_r_entry_1hot_id  out  8  one-hot oldest channel c entry targeting bank k (0 when none).

## Operation
Per-channel state:
- valid[8]: entry occupied.
- bank[8][2]: target bank of each occupied entry.
- Age matrix age[8][8]: age[i][j]=1 means entry i is older than entry j.

Allocation:
- ch_c_w_ptr is the lowest-index free entry. It is 0 when the channel is full; the value is then don't-care.
- u_channel_c_req_ready = |~valid.
- On u_channel_c_req_valid & u_channel_c_req_ready:
  - Set valid[w_ptr] and record bank[w_ptr].
  - Clear row age[w_ptr][*].
  - Set column age[j][w_ptr] for every other currently valid j, so the new entry is youngest.

Per-channel, per-bank oldest selection:
- Entry e is a candidate for bank k when valid[e] and bank[e]==k.
- ch_c_bank_k_r_entry_1hot_id has bit e set when e is a candidate and no other candidate j has age[j][e]=1.
- The result is exactly one-hot or zero.

Bank arbitration:
- Per bank k, the requesting channels are those with a nonzero ch_c_bank_k_r_entry_1hot_id.
- A round-robin pointer rr_k selects among them. Priority order is rr_k, rr_k+1, rr_k+2, modulo 3.
- bank_k_ch_1hot_id is one-hot on the granted channel.
- d_bank_k_valid = |bank_k_ch_1hot_id.

Free:
- On d_bank_k_valid & d_bank_k_ready, clear valid of the selected entry in the granted channel.
- On that handshake, set rr_k to the granted channel + 1, modulo 3.
- Without a handshake, rr_k holds and the grant is stable. The valid/grant pair must not change while valid=1 and ready=0.

## Timing
- All outputs are combinational from registered state, except u_channel_c_req_ready and ch_c_w_ptr, which are purely registered-state derived.
- No output depends combinationally on u_channel_c_req_valid or d_bank_k_ready.
- An entry allocated in cycle N is first visible to bank selection in cycle N+1. Minimum allocate-to-valid latency is 1 cycle.
- An entry freed in cycle N is allocatable in cycle N+1. Ready rises in N+1 when the channel was full.
- Simultaneous allocation and free on the same channel in the same cycle:
  - Both take effect.
  - They always target different entries, since allocation only picks free ones.
- Up to 4 frees per channel per cycle (different banks) plus 1 allocation must all take effect.
- Reset (takes priority over all other updates, including mid-operation):
  - valid=0, age=0, rr_k=0.
  - Outputs: ready=1, w_ptr=0, d_bank_k_valid=0, all 1hot ids=0.
- Full channel: ready=0. A valid with ready=0 changes no state.

## Test plan
- Reset, then idle: all ready=1, all w_ptr=0, all d_bank_k_valid=0, all 1hot ids=0.
- Channel 0 sends 3 requests to bank 2, with d_bank_2_ready=0:
  - w_ptr sequence 0,1,2.
  - ch_0_bank_2_r_entry_1hot_id=8'h01, bank_2_ch_1hot_id=3'b001.
  - Then assert ready for one cycle: the next cycle shows 8'h02 and w_ptr=0.
- Fill channel 1 with 8 requests to bank 0:
  - ready=0 after the 8th handshake, and further valids are ignored.
  - One bank 0 accept → ready=1 the next cycle, w_ptr=0.
- Channels 0, 1 and 2 each hold one bank 3 request, with d_bank_3_ready held 1: grants arrive 001, 010, 100 on consecutive cycles, then valid=0.
- Cycle N: channel 2 allocates entry 3 while bank 1 frees channel 2 entry 0. Cycle N+1 shows valid[0]=0 and entry 3 pending, with w_ptr=0.
- Reset asserted with entries pending and a bank stalled: the next cycle shows every output at its reset value, and rr_k=0.
